// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch front end: PC, reset/illop/interrupt vectors, 2-entry fetch buffer
module instr_fetch #(
  parameter logic [31:0] RESET_ADDR = 32'd0,
  parameter logic [31:0] ILLOP_ADDR = 32'd504,
  parameter logic [31:0] XADR_ADDR  = 32'd508,
  parameter int          IMEM_BYTES = 512
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc,
  input  logic [31:0] id,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  output logic [31:0] ir_link,
  output logic        ir_valid,
  input  logic        ir_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  input  logic        illop,
  input  logic        irq,
  output logic [31:0] xp,
  output logic        xp_valid
);

  localparam logic [31:0] ADDR_MASK = 32'(IMEM_BYTES - 1) & ~32'd3;

  function automatic logic [31:0] fix_addr(input logic [31:0] a);
    return a & ADDR_MASK;
  endfunction

  localparam logic [31:0] RESET_PC = RESET_ADDR & ADDR_MASK;
  localparam logic [31:0] ILLOP_PC = ILLOP_ADDR & ADDR_MASK;
  localparam logic [31:0] XADR_PC  = XADR_ADDR & ADDR_MASK;

  typedef enum logic [1:0] {
    EV_NORMAL,
    EV_ILLOP,
    EV_IRQ,
    EV_REDIRECT
  } fetch_event_e;

  logic [31:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] ent_ir_q [2];
  logic [31:0] ent_pc_q [2];
  logic [31:0] ent_ir_d [2];
  logic [31:0] ent_pc_d [2];
  logic [31:0] xp_q, xp_d;
  logic        xp_valid_q, xp_valid_d;
  logic        irq_block_q, irq_block_d;

  fetch_event_e ev;
  logic         pop;
  logic         push;
  logic         wr_slot;
  logic [31:0]  redirect_target;

  assign pc       = pc_q;
  assign ir       = ent_ir_q[0];
  assign ir_pc    = ent_pc_q[0];
  assign ir_link  = fix_addr(ent_pc_q[0] + 32'd4);
  assign ir_valid = (count_q != 2'd0);
  assign xp       = xp_q;
  assign xp_valid = xp_valid_q;

  assign pop             = ir_valid && ir_ready;
  assign push            = (count_q != 2'd2) || pop;
  assign redirect_target = fix_addr(redirect_addr);
  // After a pop the surviving entry moves to slot 0, so the new entry lands behind it.
  assign wr_slot         = ((count_q - {1'b0, pop}) != 2'd0);

  always_comb begin
    ev = EV_NORMAL;
    if (illop && ir_valid) begin
      ev = EV_ILLOP;
    end else if (irq && ir_valid && !irq_block_q) begin
      ev = EV_IRQ;
    end else if (redirect_valid) begin
      ev = EV_REDIRECT;
    end
  end

  always_comb begin
    pc_d        = pc_q;
    count_d     = count_q;
    ent_ir_d[0] = ent_ir_q[0];
    ent_ir_d[1] = ent_ir_q[1];
    ent_pc_d[0] = ent_pc_q[0];
    ent_pc_d[1] = ent_pc_q[1];
    xp_d        = xp_q;
    xp_valid_d  = 1'b0;
    irq_block_d = irq_block_q;

    case (ev)
      EV_ILLOP: begin
        pc_d        = ILLOP_PC;
        count_d     = 2'd0;
        xp_d        = ir_link;
        xp_valid_d  = 1'b1;
        irq_block_d = 1'b1;
      end
      EV_IRQ: begin
        pc_d        = XADR_PC;
        count_d     = 2'd0;
        xp_d        = ir_pc;
        xp_valid_d  = 1'b1;
        irq_block_d = 1'b1;
      end
      EV_REDIRECT: begin
        pc_d    = redirect_target;
        count_d = 2'd0;
        // A jump back below the vector area is the handler's return.
        if (redirect_target < ILLOP_PC) begin
          irq_block_d = 1'b0;
        end
      end
      default: begin
        if (pop) begin
          ent_ir_d[0] = ent_ir_q[1];
          ent_pc_d[0] = ent_pc_q[1];
        end
        if (push) begin
          ent_ir_d[wr_slot] = id;
          ent_pc_d[wr_slot] = pc_q;
          pc_d              = fix_addr(pc_q + 32'd4);
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      count_q     <= 2'd0;
      ent_ir_q[0] <= 32'd0;
      ent_ir_q[1] <= 32'd0;
      ent_pc_q[0] <= 32'd0;
      ent_pc_q[1] <= 32'd0;
      xp_q        <= 32'd0;
      xp_valid_q  <= 1'b0;
      irq_block_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      count_q     <= count_d;
      ent_ir_q[0] <= ent_ir_d[0];
      ent_ir_q[1] <= ent_ir_d[1];
      ent_pc_q[0] <= ent_pc_d[0];
      ent_pc_q[1] <= ent_pc_d[1];
      xp_q        <= xp_d;
      xp_valid_q  <= xp_valid_d;
      irq_block_q <= irq_block_d;
    end
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Fetch front end that drives the instruction-memory `pc`/`id` port and hands fetched instructions to decode. It owns the program counter, the reset, illegal-op and interrupt vectors, and a 2-entry fetch buffer with a valid/ready handshake. It sits between the combinational instruction ROM (`pc` → `id`, 128 words) and the decode/execute stage, which returns branch/jump redirects and illegal-op reports.

## Interface
- `RESET_ADDR`, 32'd0: PC after reset. This is the program selector entry.
- `ILLOP_ADDR`, 32'd504: vector taken on an illegal opcode.
- `XADR_ADDR`, 32'd508: vector taken on an interrupt.
- `IMEM_BYTES`, 512: instruction space size in bytes, a power of two. All PCs are taken modulo this value.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `pc` out 32: fetch address to the instruction ROM.
- `id` in 32: instruction returned by the ROM for `pc` in the same cycle (combinational).
- `ir` out 32: head instruction.
- `ir_pc` out 32: address of the head instruction.
- `ir_link` out 32: `ir_pc`+4 modulo `IMEM_BYTES`; this is the link value for BEQ/BNE/JMP.
- `ir_valid` out 1: the head entry is valid.
- `ir_ready` in 1: decode accepts the head this cycle.
- `redirect_valid` in 1: a taken branch or jump.
- `redirect_addr` in 32: the branch/jump target.
- `illop` in 1: decode flags the head as illegal. Only meaningful while `ir_valid` is high.
- `irq` in 1: level-sensitive interrupt request.
- `xp` out 32: exception return address, captured when a vector is taken.
- `xp_valid` out 1: one-cycle pulse when `xp` is updated.

## Operation
- The PC register drives `pc`. Every PC write is forced word-aligned (`& ~3`) and reduced modulo `IMEM_BYTES`.
- Buffer: a 2-entry FIFO of {instruction, address}. `count` ranges over 0..2. `ir`/`ir_pc` show the head; `ir_valid` = (`count` != 0).
- Pop: occurs when `ir_valid && ir_ready`.
- Push: occurs when `count` < 2, or when `count` = 2 with a pop in the same cycle. The entry pushed is {`id`, `pc`}, and the PC then advances by 4.
- Both a push and a pop in one cycle leave `count` unchanged. The FIFO sustains 1 instruction/cycle.
- If none of the events below occurs and the buffer is full with no pop, the PC holds.
- Events are resolved in this priority order; the highest one present wins:
  1. `rst`: PC ← `RESET_ADDR`, `count` ← 0, `xp` ← 0, `xp_valid` ← 0.
  2. `illop && ir_valid`: PC ← `ILLOP_ADDR`, `xp` ← `ir_link` of the head, `xp_valid` ← 1, flush.
  3. `irq && ir_valid && !irq_block`: PC ← `XADR_ADDR`, `xp` ← `ir_pc` of the head (the head is re-executed after return), `xp_valid` ← 1, flush.
  4. `redirect_valid`: PC ← `redirect_addr`, flush.
  5. Normal push/pop as described above.
- Flush means `count` ← 0 and no push that cycle. A pop in the same cycle is still considered accepted by decode, but its effect is superseded by the flush.
- `irq_block` is set by any vector entry (illop or irq). It clears on the first `redirect_valid` whose target is below `ILLOP_ADDR`, which is the return from the handler. This prevents an interrupt from re-entering its own handler.
- `illop` and `irq` asserted while `ir_valid` = 0 are ignored.

## Timing
- Reset values: `pc` = `RESET_ADDR`, `ir_valid` = 0, `ir` = 0, `ir_pc` = 0, `ir_link` = 4, `xp` = 0, `xp_valid` = 0, `irq_block` = 0.
- Fetch latency: the instruction at `pc` in cycle N appears as head in cycle N+1 if the buffer was empty.
- Redirect or vector asserted in cycle N:
  - `ir_valid` = 0 in cycle N+1, with `pc` = target.
  - The target instruction is valid in cycle N+2.
  - Penalty: 2 cycles.
- `xp` updates at the edge ending the event cycle. `xp_valid` is high for exactly cycle N+1.
- `ir_ready` may be combinational on `ir_valid`. `ir_valid` never depends combinationally on `ir_ready`.
- Wrap-around: PC 508 + 4 gives 0. `ir_link` for `ir_pc` = 508 is 0.

## Test plan
- Reset and stream: ROM word k = k. Hold `rst` 2 cycles, then `ir_ready` = 1.
  - `ir_valid` rises 1 cycle after `rst` falls.
  - `ir`/`ir_pc` = 0/0, 1/4, 2/8, … on consecutive cycles, with no bubbles.
- Backpressure: `ir_ready` = 0 for 5 cycles.
  - `count` saturates at 2 and `pc` holds at 8.
  - After `ir_ready` returns, the order 0, 1, 2, 3 is preserved with no duplicates.
- Redirect: `redirect_valid` with `redirect_addr` = 32'd83 while `count` = 2.
  - Next cycle: `ir_valid` = 0, `pc` = 80.
  - Following cycle: head `ir_pc` = 80.
- Illop: `illop` with head `ir_pc` = 200.
  - `xp` = 204 and a single `xp_valid` pulse.
  - Head becomes `ir_pc` = 504 two cycles later.
- Interrupt priority: `irq`, `illop`, and `redirect_valid` all asserted in one cycle with head `ir_pc` = 16.
  - `illop` wins and `pc` = 504.
  - `irq` held high afterward is ignored until a redirect to 20 clears `irq_block`.
  - After that, `irq` vectors to 508 with `xp` = head `ir_pc`.
- Wrap and reset mid-flush: redirect to 508 with `ir_ready` = 1.
  - Heads are 508 (`ir_link` 0), then 0.
  - Asserting `rst` in the same cycle as a redirect gives `pc` = 0, `ir_valid` = 0.
